// File: rtl/ahb_mtx_rr_arb_m2.sv
// Two-port (ports 2 and 3) round-robin arbiter for a shared AHB matrix output stage.
// Optional fixed-burst beat tracking is enabled by defining AHB_MTX_RR_BURST_HOLD_EN.
module ahb_mtx_rr_arb_m2 (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       req_port2,
  input  logic       req_port3,
  input  logic       HREADYM,
  input  logic       HSELM,
  input  logic [1:0] HTRANSM,
  input  logic [2:0] HBURSTM,
  input  logic       HMASTLOCKM,
  output logic [2:0] addr_in_port,
  output logic       no_port
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [2:0] BURST_SINGLE = 3'b000;
  localparam logic [2:0] BURST_INCR   = 3'b001;
  localparam logic [2:0] PORT2        = 3'b010;
  localparam logic [2:0] PORT3        = 3'b011;

  logic last_grant_r;  // 1'b1 = port 3 was granted last
  logic burst_cont_s;
  logic hold_s;
  logic grant_valid_s;
  logic grant_port3_s;

`ifdef AHB_MTX_RR_BURST_HOLD_EN
  logic [3:0] beat_cnt_r;

  function automatic logic [3:0] burst_beats_m1(input logic [2:0] hburst);
    logic [3:0] beats_m1;
    case (hburst)
      3'b010, 3'b011: beats_m1 = 4'd3;
      3'b100, 3'b101: beats_m1 = 4'd7;
      3'b110, 3'b111: beats_m1 = 4'd15;
      default:        beats_m1 = 4'd0;
    endcase
    return beats_m1;
  endfunction

  // Remaining-beat counter of the fixed burst currently on the routed port
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      beat_cnt_r <= 4'd0;
    end else if (HREADYM && HSELM && !no_port) begin
      case (HTRANSM)
        TRANS_NONSEQ: beat_cnt_r <= burst_beats_m1(HBURSTM);
        TRANS_SEQ:    beat_cnt_r <= (beat_cnt_r != 4'd0) ? (beat_cnt_r - 4'd1) : 4'd0;
        TRANS_IDLE:   beat_cnt_r <= 4'd0;
        default:      beat_cnt_r <= beat_cnt_r;
      endcase
    end
  end
`endif

  // Whether a SEQ beat still belongs to an unfinished burst
  always_comb begin
    burst_cont_s = 1'b0;
    if (HBURSTM == BURST_INCR) begin
      burst_cont_s = 1'b1;
    end else if (HBURSTM == BURST_SINGLE) begin
      burst_cont_s = 1'b0;
    end else begin
`ifdef AHB_MTX_RR_BURST_HOLD_EN
      burst_cont_s = (beat_cnt_r > 4'd1);
`else
      burst_cont_s = 1'b1;
`endif
    end
  end

  // Keep the current owner while it is locked or mid-sequence
  always_comb begin
    hold_s = 1'b0;
    if (!no_port && HSELM) begin
      if (HMASTLOCKM) begin
        hold_s = 1'b1;
      end else begin
        case (HTRANSM)
          TRANS_BUSY:   hold_s = 1'b1;
          TRANS_NONSEQ: hold_s = (HBURSTM != BURST_SINGLE);
          TRANS_SEQ:    hold_s = burst_cont_s;
          default:      hold_s = 1'b0;
        endcase
      end
    end else begin
      hold_s = 1'b0;
    end
  end

  // Round-robin pick: on a tie the port not granted last wins
  always_comb begin
    grant_valid_s = 1'b0;
    grant_port3_s = 1'b0;
    if (req_port2 && req_port3) begin
      grant_valid_s = 1'b1;
      grant_port3_s = !last_grant_r;
    end else if (req_port2) begin
      grant_valid_s = 1'b1;
      grant_port3_s = 1'b0;
    end else if (req_port3) begin
      grant_valid_s = 1'b1;
      grant_port3_s = 1'b1;
    end else begin
      grant_valid_s = 1'b0;
      grant_port3_s = 1'b0;
    end
  end

  // Grant registers; frozen during wait states and while held
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      no_port      <= 1'b1;
      addr_in_port <= PORT2;
      last_grant_r <= 1'b1;
    end else if (HREADYM && !hold_s) begin
      if (grant_valid_s) begin
        no_port      <= 1'b0;
        addr_in_port <= grant_port3_s ? PORT3 : PORT2;
        last_grant_r <= grant_port3_s;
      end else begin
        no_port      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ahb_mtx_rr_arb_m2.sv
// Self-checking bench for ahb_mtx_rr_arb_m2: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_ahb_mtx_rr_arb_m2;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic       req_port2, req_port3, HREADYM, HSELM, HMASTLOCKM;
  logic [1:0] HTRANSM;
  logic [2:0] HBURSTM;
  logic [2:0] addr_in_port;
  logic       no_port;

  int total = 0;
  int bad   = 0;

  ahb_mtx_rr_arb_m2 dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .req_port2(req_port2), .req_port3(req_port3),
    .HREADYM(HREADYM), .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM),
    .HMASTLOCKM(HMASTLOCKM), .addr_in_port(addr_in_port), .no_port(no_port)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic [2:0] addr;
    logic       nop;
    logic       last3;
    logic [3:0] beats;
  } mst_t;

  mst_t m;

  // Behavioural model: who owns the output after one accepted cycle
  function automatic mst_t model_step(mst_t s, bit r2, bit r3, bit sel, bit lock,
                                      logic [1:0] tr, logic [2:0] bu);
    mst_t n;
    bit   fixed;
    bit   keep;
    int   total_beats;
    int   winner;
    n           = s;
    fixed       = (bu >= 3'd2);
    total_beats = fixed ? (4 << ((int'(bu) - 2) / 2)) : 1;
    keep        = 1'b0;
    if (!s.nop && sel) begin
      if (lock) keep = 1'b1;
      else if (tr == 2'b01) keep = 1'b1;
      else if (tr == 2'b10) keep = (bu != 3'd0);
      else if (tr == 2'b11) begin
`ifdef AHB_MTX_RR_BURST_HOLD_EN
        keep = (bu == 3'd1) || (fixed && s.beats > 4'd1);
`else
        keep = (bu != 3'd0);
`endif
      end
      if (tr == 2'b10) n.beats = 4'(total_beats - 1);
      else if (tr == 2'b11) n.beats = (s.beats > 4'd0) ? s.beats - 4'd1 : 4'd0;
      else if (tr == 2'b00) n.beats = 4'd0;
    end
    if (!keep) begin
      winner = 0;
      if (r2 && r3) winner = s.last3 ? 2 : 3;
      else if (r2)  winner = 2;
      else if (r3)  winner = 3;
      if (winner == 0) begin
        n.nop = 1'b1;
      end else begin
        n.nop   = 1'b0;
        n.addr  = (winner == 3) ? 3'b011 : 3'b010;
        n.last3 = (winner == 3);
      end
    end
    return n;
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) m <= '{addr: 3'b010, nop: 1'b1, last3: 1'b1, beats: 4'd0};
    else if (HREADYM) m <= model_step(m, req_port2, req_port3, HSELM, HMASTLOCKM, HTRANSM, HBURSTM);
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {no_port,addr}=%h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Literal expectation pinned against both DUT and model
  task automatic lit(input string name, input logic [3:0] exp);
    chk({name, "_dut"}, {no_port, addr_in_port}, exp);
    chk({name, "_model"}, {m.nop, m.addr}, exp);
  endtask

  task automatic step(input bit r2, input bit r3, input bit rdy, input bit sel,
                      input bit lock, input logic [1:0] tr, input logic [2:0] bu);
    req_port2 = r2; req_port3 = r3; HREADYM = rdy; HSELM = sel;
    HMASTLOCKM = lock; HTRANSM = tr; HBURSTM = bu;
    @(posedge HCLK);
    @(negedge HCLK);
    chk("model", {no_port, addr_in_port}, {m.nop, m.addr});
  endtask

  initial begin
    req_port2 = 1'b1; req_port3 = 1'b1; HREADYM = 1'b1; HSELM = 1'b0;
    HMASTLOCKM = 1'b0; HTRANSM = 2'b00; HBURSTM = 3'b000;
    HRESETn = 1'b1;
    #1 HRESETn = 1'b0;
    @(negedge HCLK);
    lit("reset", 4'b1010);
    HRESETn = 1'b1;
    step(1, 1, 1, 0, 0, 2'b00, 3'b000);
    lit("first_grant", 4'b0010);

    // round robin with SINGLE transfers
    step(1, 1, 1, 1, 0, 2'b10, 3'b000);
    lit("rr_1", 4'b0011);
    step(1, 1, 1, 1, 0, 2'b10, 3'b000);
    lit("rr_2", 4'b0010);

    // port 2 INCR4 while port 3 requests, then IDLE
    step(1, 1, 1, 1, 0, 2'b10, 3'b011);
    lit("incr4_ns", 4'b0010);
    step(1, 1, 1, 1, 0, 2'b11, 3'b011);
    lit("incr4_s1", 4'b0010);
    step(1, 1, 1, 1, 0, 2'b11, 3'b011);
    lit("incr4_s2", 4'b0010);
    step(1, 1, 1, 1, 0, 2'b11, 3'b011);
`ifdef AHB_MTX_RR_BURST_HOLD_EN
    lit("incr4_s3", 4'b0011);
    step(1, 1, 1, 1, 0, 2'b00, 3'b000);
`else
    lit("incr4_s3", 4'b0010);
    step(1, 1, 1, 1, 0, 2'b00, 3'b000);
    lit("incr4_idle", 4'b0011);
`endif
    step(0, 1, 1, 1, 0, 2'b00, 3'b000);
    lit("to_port3", 4'b0011);

    // wait states mid-burst on port 3
    step(1, 1, 1, 1, 0, 2'b10, 3'b011);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 1, 0, 2'b11, 3'b011);
      lit("wait", 4'b0011);
    end
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 0, 2'b11, 3'b011);
    step(1, 0, 1, 1, 0, 2'b00, 3'b000);
    lit("after_wait", 4'b0010);

    // locked port 3 across IDLE with its request dropped
    step(0, 1, 1, 1, 0, 2'b00, 3'b000);
    lit("lock_grant", 4'b0011);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 1, 1, 2'b00, 3'b000);
      lit("lock_hold", 4'b0011);
    end
    step(1, 0, 1, 1, 0, 2'b00, 3'b000);
    lit("lock_release", 4'b0010);

    // reset mid-burst abandons the sequence
    step(1, 1, 1, 1, 0, 2'b10, 3'b101);
    step(1, 1, 1, 1, 0, 2'b11, 3'b101);
    lit("burst8", 4'b0010);
    HRESETn = 1'b0;
    @(posedge HCLK);
    @(negedge HCLK);
    lit("mid_reset", 4'b1010);
    HRESETn = 1'b1;
    step(1, 1, 1, 1, 0, 2'b11, 3'b101);
    lit("post_reset_tie", 4'b0010);
    step(0, 0, 1, 1, 0, 2'b00, 3'b000);
    lit("no_req", 4'b1010);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom), 1'($urandom), ($urandom % 5) != 0, ($urandom % 8) != 0,
           ($urandom % 10) == 0, 2'($urandom), 3'($urandom));
      total++;
      if (addr_in_port !== 3'b010 && addr_in_port !== 3'b011) begin
        bad++;
        $display("FAIL addr_legal: got %b want 010 or 011", addr_in_port);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
